// File: rtl/link_rx_pkg.sv
// link_rx_pkg: shared defaults, word width derivation and counter width helpers for the link receiver
package link_rx_pkg;
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_CH_WIDTH    = 8;
  localparam int DEF_BEATS       = 4;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_TOKEN_BATCH = 2;

  function automatic int word_w(input int num_ch, input int ch_width, input int beats);
    return num_ch * ch_width * beats;
  endfunction

  // bits needed to index n distinct positions (at least 1)
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // bits needed to hold values 0..max (at least 1)
  function automatic int cnt_w(input int max);
    return (max <= 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: first-word fall-through FIFO; a push while full is accepted only alongside a pop
module link_rx_fifo
  import link_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;

  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/link_rx_multich.sv
// link_rx_multich: assembles multi-channel link beats into words, buffers them and returns credit tokens
// Optional per-channel even parity checking is built when LINK_RX_PARITY_EN is defined.
module link_rx_multich
  import link_rx_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CH_WIDTH    = DEF_CH_WIDTH,
  parameter int BEATS       = DEF_BEATS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TOKEN_BATCH = DEF_TOKEN_BATCH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               io_valid_in,
  input  logic [NUM_CH*CH_WIDTH-1:0]         io_data_in,
`ifdef LINK_RX_PARITY_EN
  input  logic [NUM_CH-1:0]                  io_parity_in,
  output logic                               parity_err,
`endif
  output logic                               io_token_out,
  output logic                               core_valid_out,
  output logic [NUM_CH*CH_WIDTH*BEATS-1:0]   core_data_out,
  input  logic                               core_ready,
  output logic                               overflow_err
);
  localparam int WORD_W = word_w(NUM_CH, CH_WIDTH, BEATS);
  localparam int BEAT_W = NUM_CH * CH_WIDTH;
  localparam int BW     = ptr_w(BEATS);
  localparam int PW     = cnt_w(TOKEN_BATCH - 1);
  localparam int CW     = cnt_w(DEPTH);

  logic [BW-1:0]                r_beat;
  logic [(BEATS-1)*BEAT_W-1:0]  r_word;
  logic [PW-1:0]                r_pop_cnt;
  logic                         r_token, r_ovf;
  logic                         w_last, w_push, w_pop, w_batch, w_full, w_empty;
  logic [WORD_W-1:0]            w_word;
  logic [CW-1:0]                w_count;

  assign w_last         = r_beat == BW'(BEATS - 1);
  assign w_push         = io_valid_in && w_last;
  assign w_word         = {io_data_in, r_word};
  assign w_pop          = core_ready && !w_empty;
  assign w_batch        = r_pop_cnt == PW'(TOKEN_BATCH - 1);
  assign core_valid_out = w_count != '0;
  assign io_token_out   = r_token;
  assign overflow_err   = r_ovf;

  // beat counter and partial word; the final beat goes straight into the FIFO with the stored beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_word <= '0;
    end else if (io_valid_in) begin
      r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (!w_last) r_word[r_beat*BEAT_W +: BEAT_W] <= io_data_in;
    end
  end

  // pop batching toggles the credit token once per TOKEN_BATCH pops; overflow is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_cnt <= '0;
      r_token   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pop_cnt <= w_batch ? '0 : r_pop_cnt + 1'b1;
        if (w_batch) r_token <= ~r_token;
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

`ifdef LINK_RX_PARITY_EN
  logic [NUM_CH-1:0] w_par_mis;
  logic              r_par_err;

  assign parity_err = r_par_err;

  // a channel mismatches when its data plus parity bit hold an odd number of ones
  always_comb begin
    w_par_mis = '0;
    for (int c = 0; c < NUM_CH; c++) w_par_mis[c] = ^io_data_in[c*CH_WIDTH +: CH_WIDTH] ^ io_parity_in[c];
  end

  // sticky parity error; the beat itself is still assembled and stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par_err <= 1'b0;
    else if (io_valid_in && |w_par_mis) r_par_err <= 1'b1;
  end
`endif

  link_rx_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (core_data_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_link_rx_multich.sv
// tb_link_rx_multich: directed and randomized checks of link_rx_multich against a queue-based model
module tb_link_rx_multich;
  localparam int NUM_CH = 2, CH_WIDTH = 8, BEATS = 4, DEPTH = 8, TB = 2;
  localparam int BEAT_W = NUM_CH * CH_WIDTH;
  localparam int WW = BEAT_W * BEATS;

  logic clk = 1'b0, rst_n = 1'b0, io_valid_in = 1'b0, core_ready = 1'b0;
  logic [BEAT_W-1:0] io_data_in = '0;
  logic io_token_out, core_valid_out, overflow_err;
  logic [WW-1:0] core_data_out;
`ifdef LINK_RX_PARITY_EN
  logic [NUM_CH-1:0] io_parity_in = '0;
  logic parity_err;
  bit m_perr;
`endif

  int checks = 0, failures = 0;
  logic [WW-1:0] q[$];
  logic [WW-1:0] m_part;
  int m_beat, m_pops;
  bit m_ovf, flip;

  always #5 clk = ~clk;

  link_rx_multich #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .BEATS(BEATS), .DEPTH(DEPTH), .TOKEN_BATCH(TB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_valid_in    (io_valid_in),
    .io_data_in     (io_data_in),
`ifdef LINK_RX_PARITY_EN
    .io_parity_in   (io_parity_in),
    .parity_err     (parity_err),
`endif
    .io_token_out   (io_token_out),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .core_ready     (core_ready),
    .overflow_err   (overflow_err)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("valid", core_valid_out, q.size() != 0);
    if (q.size() != 0) chk("data", core_data_out, q[0]);
    chk("token", io_token_out, (m_pops / TB) % 2);
    chk("overflow", overflow_err, m_ovf);
`ifdef LINK_RX_PARITY_EN
    chk("parity", parity_err, m_perr);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    m_part = '0;
    m_beat = 0;
    m_pops = 0;
    m_ovf = 0;
`ifdef LINK_RX_PARITY_EN
    m_perr = 0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    io_valid_in = 1'b0;
    core_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    check_outs();
  endtask

  task automatic cyc(input bit v, input logic [BEAT_W-1:0] d, input bit rdy);
    int pre;
    bit pop, push;
    logic [WW-1:0] w;
    io_valid_in = v;
    io_data_in = d;
    core_ready = rdy;
`ifdef LINK_RX_PARITY_EN
    for (int c = 0; c < NUM_CH; c++) io_parity_in[c] = ^d[c*CH_WIDTH +: CH_WIDTH] ^ (flip && c == 1);
    if (v && flip) m_perr = 1;
`endif
    pre = q.size();
    pop = pre > 0 && rdy;
    push = v && m_beat == BEATS - 1;
    w = '0;
    if (v) begin
      m_part[m_beat*BEAT_W +: BEAT_W] = d;
      w = m_part;
      m_beat = (m_beat + 1) % BEATS;
    end
    @(posedge clk);
    #1;
    io_valid_in = 1'b0;
    if (pop) begin
      void'(q.pop_front());
      m_pops++;
    end
    if (push) begin
      if (pre < DEPTH || pop) q.push_back(w);
      else m_ovf = 1;
    end
    check_outs();
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit rdy);
    for (int b = 0; b < BEATS; b++) cyc(1'b1, w[b*BEAT_W +: BEAT_W], rdy);
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [WW-1:0] w;
    flip = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outs();
    chk("reset_valid", core_valid_out, 0);
    chk("reset_token", io_token_out, 0);

    cyc(1'b1, 16'h0201, 1'b0);
    cyc(1'b1, 16'h0403, 1'b0);
    cyc(1'b1, 16'h0605, 1'b0);
    chk("no_word_yet", core_valid_out, 0);
    cyc(1'b1, 16'h0807, 1'b0);
    chk("word_valid", core_valid_out, 1);
    chk("word_value", core_data_out, 64'h0807060504030201);
    cyc(1'b0, '0, 1'b1);
    chk("word_popped", core_valid_out, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(rnd_word(), 1'b0);
    chk("full_no_err", overflow_err, 0);
    send_word(rnd_word(), 1'b0);
    chk("full_overflow", overflow_err, 1);
    repeat (DEPTH) cyc(1'b0, '0, 1'b1);
    chk("drained", core_valid_out, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word(rnd_word(), 1'b0);
    w = rnd_word();
    for (int b = 0; b < BEATS - 1; b++) cyc(1'b1, w[b*BEAT_W +: BEAT_W], 1'b0);
    cyc(1'b1, w[(BEATS-1)*BEAT_W +: BEAT_W], 1'b1);
    chk("push_pop_full_no_err", overflow_err, 0);
    cyc(1'b0, '0, 1'b0);
    repeat (DEPTH) cyc(1'b0, '0, 1'b1);
    chk("push_pop_drained", core_valid_out, 0);

    do_reset();
    for (int i = 0; i < 5; i++) send_word(rnd_word(), 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk($sformatf("token_after_pop%0d", i), io_token_out, (i == 2 || i == 3) ? 1 : 0);
      cyc(1'b0, '0, 1'b0);
    end

    cyc(1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0);
    do_reset();
    for (int b = 0; b < BEATS; b++) cyc(1'b1, 16'hAAAA, 1'b0);
    chk("reset_mid_word", core_data_out, {WW/8{8'hAA}});
    chk("reset_mid_token", io_token_out, 0);
    cyc(1'b0, '0, 1'b1);
    chk("reset_mid_single", core_valid_out, 0);

    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit rdy;
      rdy = (i / 100) % 2 == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      cyc($urandom_range(0, 1) == 1, 16'($urandom()), rdy);
    end
    repeat (DEPTH + 2) cyc(1'b0, '0, 1'b1);
    chk("random_drained", core_valid_out, 0);

`ifdef LINK_RX_PARITY_EN
    do_reset();
    w = rnd_word();
    cyc(1'b1, w[0 +: BEAT_W], 1'b0);
    flip = 1;
    cyc(1'b1, w[BEAT_W +: BEAT_W], 1'b0);
    flip = 0;
    chk("parity_set", parity_err, 1);
    cyc(1'b1, w[2*BEAT_W +: BEAT_W], 1'b0);
    cyc(1'b1, w[3*BEAT_W +: BEAT_W], 1'b0);
    chk("parity_word_kept", core_data_out, w);
    chk("parity_sticky", parity_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/link_rx_multich.md
LINK_RX_MULTICH -- requirements
Module: link_rx_multich

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of link channels.
REQ-002 SHALL have parameter CH_WIDTH, default 8, bits per channel per beat.
REQ-003 SHALL have parameter BEATS, default 4, beats per assembled word (>=2).
REQ-004 SHALL have parameter DEPTH, default 8, receive FIFO words (power of two, >=2).
REQ-005 SHALL have parameter TOKEN_BATCH, default 2, dequeues per token toggle (1..DEPTH).
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 io_valid_in  in  1  link beat valid.
REQ-010 io_data_in  in  NUM_CH*CH_WIDTH  beat data; channel c at [c*CH_WIDTH +: CH_WIDTH].
REQ-011 io_token_out  out  1  credit return; one toggle = TOKEN_BATCH words freed.
REQ-012 core_valid_out  out  1  FIFO head valid.
REQ-013 core_data_out  out  NUM_CH*CH_WIDTH*BEATS (WORD_W)  FIFO head word.
REQ-014 core_ready  in  1  core accepts head.
REQ-015 overflow_err  out  1  sticky: word arrived while FIFO full.

Function
REQ-016 SHALL count beats 0..BEATS-1, incrementing on each io_valid_in cycle and wrapping to 0 after BEATS-1.
REQ-017 SHALL place beat b, channel c at core_data_out[(b*NUM_CH+c)*CH_WIDTH +: CH_WIDTH].
REQ-018 SHALL push the assembled word on the edge sampling beat BEATS-1; core_valid_out SHALL assert the following cycle (1-cycle latency when empty).
REQ-019 SHALL hold beat count and partial word unchanged while io_valid_in is low (gaps allowed between beats).
REQ-020 SHALL present the FIFO head combinationally (first-word fall-through); head SHALL stay stable while core_valid_out && !core_ready.
REQ-021 SHALL pop on core_valid_out && core_ready; pop when empty is impossible by construction.
REQ-022 SHALL keep occupancy 0..DEPTH; simultaneous push and pop leaves occupancy unchanged and SHALL be accepted even when full.
REQ-023 Push while full without same-cycle pop SHALL drop the word, leave FIFO contents intact and set overflow_err until reset.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH.
REQ-025 SHALL count pops 0..TOKEN_BATCH-1; on the pop completing a batch, io_token_out SHALL toggle (registered, next cycle) and the counter return to 0.

Reset
REQ-026 On rst_n low: beat count 0, partial word discarded, FIFO empty, pop counter 0, io_token_out 0, core_valid_out 0, overflow_err 0; core_data_out don't-care while core_valid_out is 0.
REQ-027 Reset mid-word or mid-batch SHALL discard partial state with no token toggle; first beat after release is beat 0.

Configuration
REQ-028 With LINK_RX_PARITY_EN defined: adds input io_parity_in [NUM_CH] (even parity per channel per beat) and output parity_err (sticky); a beat with any mismatching channel SHALL set parity_err; the word is still stored.
REQ-029 Without LINK_RX_PARITY_EN: neither port exists and no parity logic is built.

Structure
REQ-030 Package link_rx_pkg SHALL hold default parameter constants, WORD_W derivation and pointer/count width helpers.
REQ-031 FIFO storage and pointers SHALL be a sub-module link_rx_fifo (WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-032 Defaults; 4 beats 0x0201,0x0403,0x0605,0x0807 -> core_valid_out next cycle, core_data_out 0x0807060504030201.
REQ-033 core_ready=0; send 8 words -> 8 held, no error; 9th word -> dropped, overflow_err=1; drain -> 8 original words in order.
REQ-034 Full FIFO, core_ready=1, 9th word final beat same cycle as pop -> accepted, count stays 8, overflow_err=0.
REQ-035 TOKEN_BATCH=2; 5 pops -> io_token_out 0->1 after pop 2, 1->0 after pop 4, unchanged after pop 5.
REQ-036 2 beats then rst_n low 1 cycle, then 4 beats of 0xAA -> single word all 0xAA, io_token_out 0.
REQ-037 LINK_RX_PARITY_EN; beat with ch1 parity flipped -> parity_err=1 sticky, word still delivered.
